// File: rtl/dma_ram_pkg.sv
// Shared definitions for the segmented DMA RAM demux blocks: default
// parameter values and helpers for splitting the DMA-side select into a
// port index (MSBs) and the RAM-side select (LSBs).
package dma_ram_pkg;

  localparam int DEFAULT_PORTS           = 2;
  localparam int DEFAULT_SEG_COUNT       = 2;
  localparam int DEFAULT_SEG_DATA_WIDTH  = 64;
  localparam int DEFAULT_SEG_ADDR_WIDTH  = 8;
  localparam int DEFAULT_S_RAM_SEL_WIDTH = 2;
  localparam int DEFAULT_FIFO_ADDR_WIDTH = 5;

  // Number of select MSBs that carry the port index.
  function automatic int port_idx_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // The port index must address every port exactly, so PORTS has to be a
  // power of two and at least two.
  function automatic bit ports_valid(input int ports);
    return (ports >= 2) && ((ports & (ports - 1)) == 0);
  endfunction

endpackage

// File: rtl/dma_ram_rd_route_fifo.sv
// Per-segment routing FIFO. Remembers which RAM port each accepted read
// command went to, so responses can be returned to the DMA side in order.
import dma_ram_pkg::*;

module dma_ram_rd_route_fifo #(
  parameter int PORT_W = 1,
  parameter int ADDR_W = DEFAULT_FIFO_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [PORT_W-1:0] push_port,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [PORT_W-1:0] head
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [PORT_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push_ok;
  logic              pop_ok;

  // A push into a full FIFO is ignored even if a pop happens in the same
  // cycle: the slot is only freed at the clock edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == (ADDR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_port;
  end

  // Pointers wrap naturally modulo depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_ram_demux_rd.sv
// Read-path demux for segmented DMA RAM. Each segment independently
// forwards read commands to one of PORTS RAM interfaces (chosen by the
// select MSBs) through a one-deep output register, and returns responses
// to the DMA side in command order using a routing FIFO.
import dma_ram_pkg::*;

module dma_ram_demux_rd #(
  parameter int PORTS           = DEFAULT_PORTS,
  parameter int SEG_COUNT       = DEFAULT_SEG_COUNT,
  parameter int SEG_DATA_WIDTH  = DEFAULT_SEG_DATA_WIDTH,
  parameter int SEG_ADDR_WIDTH  = DEFAULT_SEG_ADDR_WIDTH,
  parameter int S_RAM_SEL_WIDTH = DEFAULT_S_RAM_SEL_WIDTH,
  parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + $clog2(PORTS),
  parameter int FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [SEG_COUNT*M_RAM_SEL_WIDTH-1:0]          ctrl_rd_cmd_sel,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]           ctrl_rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                          ctrl_rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                          ctrl_rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]           ctrl_rd_resp_data,
  output logic [SEG_COUNT-1:0]                          ctrl_rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                          ctrl_rd_resp_ready,
  output logic [PORTS*SEG_COUNT*S_RAM_SEL_WIDTH-1:0]    ram_rd_cmd_sel,
  output logic [PORTS*SEG_COUNT*SEG_ADDR_WIDTH-1:0]     ram_rd_cmd_addr,
  output logic [PORTS*SEG_COUNT-1:0]                    ram_rd_cmd_valid,
  input  logic [PORTS*SEG_COUNT-1:0]                    ram_rd_cmd_ready,
  input  logic [PORTS*SEG_COUNT*SEG_DATA_WIDTH-1:0]     ram_rd_resp_data,
  input  logic [PORTS*SEG_COUNT-1:0]                    ram_rd_resp_valid,
  output logic [PORTS*SEG_COUNT-1:0]                    ram_rd_resp_ready
);

  localparam int PORT_W = port_idx_width(PORTS);

  // Reject port counts the select MSBs cannot address one-to-one.
  if (!ports_valid(PORTS)) begin : g_bad_ports
    $error("dma_ram_demux_rd: PORTS must be a power of two >= 2");
  end

  for (genvar s = 0; s < SEG_COUNT; s++) begin : g_seg

    logic [M_RAM_SEL_WIDTH-1:0] cmd_sel_in;
    logic [PORT_W-1:0]          cmd_port;
    logic [PORTS-1:0]           ram_cmd_ready_seg;
    logic [PORTS-1:0]           ram_resp_valid_seg;
    logic [SEG_DATA_WIDTH-1:0]  ram_resp_data_seg [PORTS];

    logic                       reg_valid;
    logic [PORT_W-1:0]          reg_port;
    logic [S_RAM_SEL_WIDTH-1:0] reg_sel;
    logic [SEG_ADDR_WIDTH-1:0]  reg_addr;

    logic                       cmd_ready;
    logic                       cmd_accept;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [PORT_W-1:0]          fifo_head;
    logic                       resp_valid;
    logic                       resp_xfer;

    assign cmd_sel_in = ctrl_rd_cmd_sel[s*M_RAM_SEL_WIDTH +: M_RAM_SEL_WIDTH];
    assign cmd_port   = cmd_sel_in[M_RAM_SEL_WIDTH-1 -: PORT_W];

    // Ready needs room to record the route and a free (or draining) register;
    // gating with rst_n keeps ready low for the whole reset.
    assign cmd_ready  = rst_n && !fifo_full &&
                        (!reg_valid || ram_cmd_ready_seg[reg_port]);
    assign cmd_accept = ctrl_rd_cmd_valid[s] && cmd_ready;
    assign ctrl_rd_cmd_ready[s] = cmd_ready;

    // Responses only flow from the port at the FIFO head; an empty FIFO
    // blocks everything, including stray responses after a reset.
    assign resp_valid = !fifo_empty && ram_resp_valid_seg[fifo_head];
    assign resp_xfer  = resp_valid && ctrl_rd_resp_ready[s];
    assign ctrl_rd_resp_valid[s] = resp_valid;
    assign ctrl_rd_resp_data[s*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] =
      ram_resp_data_seg[fifo_head];

    for (genvar p = 0; p < PORTS; p++) begin : g_port
      localparam int IDX = p*SEG_COUNT + s;

      assign ram_cmd_ready_seg[p]  = ram_rd_cmd_ready[IDX];
      assign ram_resp_valid_seg[p] = ram_rd_resp_valid[IDX];
      assign ram_resp_data_seg[p]  = ram_rd_resp_data[IDX*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];

      assign ram_rd_cmd_valid[IDX] = reg_valid && (reg_port == PORT_W'(p));
      assign ram_rd_cmd_sel[IDX*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH] = reg_sel;
      assign ram_rd_cmd_addr[IDX*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]  = reg_addr;
      assign ram_rd_resp_ready[IDX] = !fifo_empty && (fifo_head == PORT_W'(p)) &&
                                      ctrl_rd_resp_ready[s];
    end

    // Command output register: load on accept, empty once the RAM takes it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_valid <= 1'b0;
        reg_port  <= '0;
        reg_sel   <= '0;
        reg_addr  <= '0;
      end else if (cmd_accept) begin
        reg_valid <= 1'b1;
        reg_port  <= cmd_port;
        reg_sel   <= cmd_sel_in[S_RAM_SEL_WIDTH-1:0];
        reg_addr  <= ctrl_rd_cmd_addr[s*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
      end else if (reg_valid && ram_cmd_ready_seg[reg_port]) begin
        reg_valid <= 1'b0;
      end
    end

    dma_ram_rd_route_fifo #(
      .PORT_W (PORT_W),
      .ADDR_W (FIFO_ADDR_WIDTH)
    ) u_route_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_accept),
      .push_port (cmd_port),
      .pop       (resp_xfer),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
    );

  end

endmodule
